// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: NPC redirect opcodes and FETCH state codes.
// S_TRAP exists only when PC_MISALIGN_TRAP_EN is defined.
package pc_fetch_ctrl_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_KILL = 3'd3,
    S_HOLD = 3'd4
`ifdef PC_MISALIGN_TRAP_EN
    ,S_TRAP = 3'd5
`endif
  } fetch_state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect-target adder. With PC_MISALIGN_TRAP_EN the raw target is passed
// through with a misaligned flag; otherwise the low two bits are forced to zero.
module npc_target_calc
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      rd_op_i,
  input  logic [XLEN-1:0] rd_pc_i,
  input  logic [XLEN-1:0] rd_imm_i,
  input  logic [XLEN-1:0] rd_rs1_i,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misaligned_o,
`endif
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] rawTarget;

  // Unknown opcodes fall back to sequential flow.
  always_comb begin
    case (rd_op_i)
      NPC_BRANCH, NPC_JUMP: rawTarget = rd_pc_i + rd_imm_i;
      NPC_JALR:             rawTarget = (rd_rs1_i + rd_imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
      default:              rawTarget = rd_pc_i + XLEN'(4);
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned_o = |rawTarget[1:0];
  assign target_o     = rawTarget;
`else
  assign target_o     = {rawTarget[XLEN-1:2], 2'b00};
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer owning the architectural PC: one imem request in flight, one-entry decode buffer.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready,
  input  logic            rd_valid,
  input  logic [2:0]      rd_op,
  input  logic [XLEN-1:0] rd_pc,
  input  logic [XLEN-1:0] rd_imm,
  input  logic [XLEN-1:0] rd_rs1,
  output logic            trap_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifPc_q, ifPc_d;
  logic [XLEN-1:0] ifInstr_q, ifInstr_d;
  logic            trapPend_q, trapPend_d;
  logic            reqValid_q, ifValid_q;
  logic [XLEN-1:0] tgtPc;
  logic            mis;

`ifdef PC_MISALIGN_TRAP_EN
  localparam fetch_state_e TrapState = S_TRAP;
  logic tgtMis;
  logic trapValid_q;

  npc_target_calc #(.XLEN(XLEN)) u_npc (
    .rd_op_i      (rd_op),
    .rd_pc_i      (rd_pc),
    .rd_imm_i     (rd_imm),
    .rd_rs1_i     (rd_rs1),
    .misaligned_o (tgtMis),
    .target_o     (tgtPc)
  );
  assign mis = tgtMis;
`else
  // Without the trap option targets are always aligned, so the trap path is never taken.
  localparam fetch_state_e TrapState = S_REQ;

  npc_target_calc #(.XLEN(XLEN)) u_npc (
    .rd_op_i  (rd_op),
    .rd_pc_i  (rd_pc),
    .rd_imm_i (rd_imm),
    .rd_rs1_i (rd_rs1),
    .target_o (tgtPc)
  );
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifPc_d     = ifPc_q;
    ifInstr_d  = ifInstr_q;
    trapPend_d = trapPend_q;
    if (rd_valid) pc_d = tgtPc;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (rd_valid && mis) begin
          state_d = TrapState;
          ifPc_d  = tgtPc;
        end
      end
      // A redirect on the handshake cycle leaves a stale request that must be drained.
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          if (rd_valid) begin
            state_d    = S_KILL;
            trapPend_d = mis;
          end
        end else if (rd_valid && mis) begin
          state_d = TrapState;
          ifPc_d  = tgtPc;
        end
      end
      S_WAIT: begin
        if (rd_valid) begin
          if (imem_rsp_valid) begin
            state_d = mis ? TrapState : S_REQ;
            if (mis) ifPc_d = tgtPc;
          end else begin
            state_d    = S_KILL;
            trapPend_d = mis;
          end
        end else if (imem_rsp_valid) begin
          ifInstr_d = imem_rsp_data;
          ifPc_d    = pc_q;
          pc_d      = pc_q + XLEN'(4);
          state_d   = S_HOLD;
        end
      end
      S_KILL: begin
        if (rd_valid) trapPend_d = mis;
        if (imem_rsp_valid) begin
          trapPend_d = 1'b0;
          if (rd_valid ? mis : trapPend_q) begin
            state_d = TrapState;
            ifPc_d  = rd_valid ? tgtPc : pc_q;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (rd_valid) begin
          state_d = mis ? TrapState : S_REQ;
          if (mis) ifPc_d = tgtPc;
        end else if (if_ready) begin
          state_d = S_REQ;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP: begin
        if (rd_valid) begin
          if (mis) ifPc_d = tgtPc;
          else     state_d = S_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ifPc_q      <= '0;
      ifInstr_q   <= '0;
      trapPend_q  <= 1'b0;
      reqValid_q  <= 1'b0;
      ifValid_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trapValid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifPc_q      <= ifPc_d;
      ifInstr_q   <= ifInstr_d;
      trapPend_q  <= trapPend_d;
      reqValid_q  <= (state_d == S_REQ);
      ifValid_q   <= (state_d == S_HOLD);
`ifdef PC_MISALIGN_TRAP_EN
      trapValid_q <= (state_d == S_TRAP);
`endif
    end
  end

  assign imem_req_valid = reqValid_q;
  assign imem_req_addr  = pc_q;
  assign if_valid       = ifValid_q;
  assign if_pc          = ifPc_q;
  assign if_instr       = ifInstr_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign trap_valid     = trapValid_q;
`else
  assign trap_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic, checked against a
// transaction-level model of fetch order, stale responses and the decode buffer.
module tb_pc_fetch_ctrl;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [2:0]  rd_op = '0;
  logic [31:0] rd_pc = '0;
  logic [31:0] rd_imm = '0;
  logic [31:0] rd_rs1 = '0;
  logic        trap_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: where the next accepted request must point, what is in flight,
  // and what decode should see.
  logic [31:0] nextFetch = '0;
  logic [31:0] outAddr = '0;
  logic [31:0] expIfPc = '0;
  logic [31:0] expIfInstr = '0;
  bit          outstanding = 0;
  bit          outStale = 0;
  bit          expIfValid = 0;
  bit          expTrap = 0;
  bit          trapPend = 0;
  logic [31:0] accQ[$];
  int          accGap = 0;
  int          maxGap = 0;
  int          accCount = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .rd_valid       (rd_valid),
    .rd_op          (rd_op),
    .rd_pc          (rd_pc),
    .rd_imm         (rd_imm),
    .rd_rs1         (rd_rs1),
    .trap_valid     (trap_valid)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] refTarget(input logic [2:0] op, input logic [31:0] pc,
                                            input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    case (op)
      OP_BRANCH, OP_JUMP: t = pc + imm;
      OP_JALR:            t = (rs1 + imm) & 32'hFFFF_FFFE;
      default:            t = pc + 32'd4;
    endcase
`ifndef PC_MISALIGN_TRAP_EN
    t = t & 32'hFFFF_FFFC;
`endif
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit rsp, input bit ifr);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp && outstanding;
    imem_rsp_data  = (rsp && outstanding) ? memWord(outAddr) : 32'hDEAD_BEEF;
    if_ready       = ifr;
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1);
    rd_valid = 1'b1;
    rd_op    = op;
    rd_pc    = pc;
    rd_imm   = imm;
    rd_rs1   = rs1;
  endtask

  // Advance one clock: update the model from this cycle's handshakes, then check outputs.
  task automatic tick();
    bit          acc;
    bit          mis;
    logic [31:0] tgt;
    acc = (imem_req_valid === 1'b1) && imem_req_ready;
    if (acc) begin
      checkOutput("req_addr", imem_req_addr, nextFetch);
      checkOutput("one_outstanding", {31'b0, outstanding}, 32'd0);
      accQ.push_back(imem_req_addr);
      accCount++;
    end
    tgt = refTarget(rd_op, rd_pc, rd_imm, rd_rs1);
    mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    mis = (tgt[1:0] != 2'b00);
`endif
    if (expIfValid && (if_ready || rd_valid)) expIfValid = 0;
    if (imem_rsp_valid) begin
      if (!outStale && !rd_valid) begin
        expIfValid = 1;
        expIfPc    = outAddr;
        expIfInstr = memWord(outAddr);
        nextFetch  = outAddr + 32'd4;
      end
      if (trapPend && !rd_valid) begin
        expTrap = 1;
        expIfPc = nextFetch;
      end
      trapPend    = 0;
      outstanding = 0;
    end
    if (acc) begin
      outstanding = 1;
      outStale    = 0;
      outAddr     = imem_req_addr;
    end
    if (rd_valid) begin
      nextFetch = tgt;
      expTrap   = 0;
      trapPend  = 0;
      if (outstanding) begin
        outStale = 1;
        trapPend = mis;
      end else if (mis) begin
        expTrap = 1;
        expIfPc = tgt;
      end
    end
    accGap = acc ? 0 : accGap + 1;
    if (accGap > maxGap) maxGap = accGap;
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    checkOutput("if_valid", {31'b0, if_valid}, {31'b0, expIfValid});
    if (expIfValid) begin
      checkOutput("if_pc", if_pc, expIfPc);
      checkOutput("if_instr", if_instr, expIfInstr);
    end
    checkOutput("trap_valid", {31'b0, trap_valid}, {31'b0, expTrap});
    if (expTrap) checkOutput("trap_pc", if_pc, expIfPc);
    checkOutput("req_while_busy",
                {31'b0, imem_req_valid && (outstanding || expTrap || expIfValid)}, 32'd0);
  endtask

  // Drain in-flight work and consume the buffer until a request is pending with ready low.
  task automatic settleToReq();
    for (int k = 0; k < 30 && !(imem_req_valid && !outstanding && !expIfValid); k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick();
    end
    checkOutput("settle_timeout", {31'b0, imem_req_valid && !outstanding}, 32'd1);
  endtask

  task automatic runUntilAcc(input string tag, input bit rsp, input bit ifr);
    accQ.delete();
    for (int k = 0; k < 20 && accQ.size() == 0; k++) begin
      applyStimulus(1'b1, rsp, ifr);
      tick();
    end
    checkOutput({tag, "_timeout"}, accQ.size(), 32'd1);
  endtask

  initial begin
    bit          rdy, rsp, ifr;
    logic [31:0] alignMask;
    logic [31:0] rnd;

    #12;
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_trap", {31'b0, trap_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Straight-line fetch with an always-ready memory and a one-cycle response.
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
    end
    checkOutput("seq_count", {31'b0, accQ.size() >= 3}, 32'd1);
    if (accQ.size() >= 3) begin
      checkOutput("seq_addr0", accQ[0], 32'h0);
      checkOutput("seq_addr1", accQ[1], 32'h4);
      checkOutput("seq_addr2", accQ[2], 32'h8);
    end

    // Branch backwards while decode holds an instruction.
    for (int k = 0; k < 20 && !expIfValid; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
    end
    checkOutput("hold_reached", {31'b0, expIfValid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    redirect(OP_BRANCH, 32'h10, 32'hFFFF_FFF0, 32'h0);
    tick();
    checkOutput("branch_drop", {31'b0, if_valid}, 32'd0);
    runUntilAcc("branch_acc", 1'b0, 1'b1);
    if (accQ.size() > 0) checkOutput("branch_addr", accQ[0], 32'h0);

    // JALR while the request at 0x0 is outstanding: its response must be discarded.
    applyStimulus(1'b1, 1'b0, 1'b1);
    redirect(OP_JALR, 32'h0, 32'h4, 32'h101);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("jalr_no_if", {31'b0, if_valid}, 32'd0);
    runUntilAcc("jalr_acc", 1'b0, 1'b1);
    if (accQ.size() > 0) checkOutput("jalr_addr", accQ[0], 32'h104);

    // Memory stalls; a jump mid-stall must yield a single request at the new target.
    settleToReq();
    accQ.delete();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == 2) redirect(OP_JUMP, 32'h100, 32'h100, 32'h0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
    end
    checkOutput("stall_single_req", accQ.size(), 32'd1);
    if (accQ.size() > 0) checkOutput("stall_addr", accQ[0], 32'h200);

    // Redirect and response in the same cycle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    redirect(OP_BRANCH, 32'h300, 32'h20, 32'h0);
    tick();
    checkOutput("collide_no_if", {31'b0, if_valid}, 32'd0);
    runUntilAcc("collide_acc", 1'b0, 1'b0);
    if (accQ.size() > 0) checkOutput("collide_addr", accQ[0], 32'h320);

`ifdef PC_MISALIGN_TRAP_EN
    settleToReq();
    applyStimulus(1'b0, 1'b0, 1'b0);
    redirect(OP_JUMP, 32'h0, 32'h6, 32'h0);
    tick();
    checkOutput("trap_set", {31'b0, trap_valid}, 32'd1);
    checkOutput("trap_if_pc", if_pc, 32'h6);
    accQ.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
    end
    checkOutput("trap_no_req", accQ.size(), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    redirect(OP_JUMP, 32'h40, 32'h0, 32'h0);
    tick();
    checkOutput("trap_clear", {31'b0, trap_valid}, 32'd0);
    runUntilAcc("trap_exit_acc", 1'b0, 1'b0);
    if (accQ.size() > 0) checkOutput("trap_exit_addr", accQ[0], 32'h40);
    alignMask = 32'hFFFF_FFFC;
`else
    alignMask = 32'hFFFF_FFFF;
`endif

    // Random traffic: handshake timing, redirects of every opcode, wrapping targets.
    maxGap   = 0;
    accGap   = 0;
    accCount = 0;
    for (int k = 0; k < 2000; k++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rsp = ($urandom_range(0, 9) < 5);
      ifr = ($urandom_range(0, 9) < 5);
      applyStimulus(rdy, rsp, ifr);
      if ($urandom_range(0, 9) == 0) begin
        rnd = $urandom();
        redirect(3'($urandom_range(0, 7)), rnd & 32'hFFFF_FFFC,
                 $urandom() & alignMask, $urandom() & alignMask);
      end
      tick();
    end
    checkOutput("progress", {31'b0, accCount > 50}, 32'd1);
    checkOutput("max_gap", {31'b0, maxGap < 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
